apb_mem_target: RTL

//  APB completer with a local byte-wide register array; sits directly downstream of the DMA APB master
//  on either target port (psel0/psel1 segment).

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_tgt_regfile.sv | 34 +++
 rtl/apb_mem_target.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions for the DMA master and its memory targets.
// Holds bus widths, the target FSM state type and the wait-counter width.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    // Wait counter must be able to hold any WAIT_CYCLES value from 0 to 15.
    localparam int WAIT_CNT_W = $clog2(16);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLD
    } apb_tgt_state_t;

endpackage

// File: rtl/apb_tgt_regfile.sv
// Byte-wide local storage for the APB memory target.
// Provides one synchronous write port, one combinational read port and an asynchronous clear.
module apb_tgt_regfile
    import apb_pkg::*;
#(
    parameter int DATA_W = APB_DATA_W,
    parameter int DEPTH  = 64,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Every entry returns to zero whenever reset is asserted, even mid-transfer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_mem_target.sv
// APB completer backed by a local register array, with programmable wait states
// and an error response for accesses outside the populated window.
module apb_mem_target
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              perr
);

    localparam int IDX_W = ADDR_W - 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [IDX_W:0]      DEPTH_LIM = (IDX_W + 1)'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);

    apb_tgt_state_t          state;
    apb_tgt_state_t          next_state;
    logic [WAIT_CNT_W-1:0]   cnt;
    logic [WAIT_CNT_W-1:0]   cnt_next;
    logic                    capture;

    logic [IDX_W-1:0]        cap_idx;
    logic                    cap_write;
    logic [DATA_W-1:0]       cap_wdata;

    logic                    idx_ok;
    logic                    enter_resp;
    logic                    mem_we;
    logic [DATA_W-1:0]       mem_rdata;

    // The top address bit only selects the segment upstream, so it carries no meaning here.
    logic                    unused_seg_bit;
    assign unused_seg_bit = paddr[ADDR_W-1];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // WAIT lasts WAIT_CYCLES+1 cycles; dropping psel or penable there abandons the transfer.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (psel && penable) begin
                    next_state = WAIT;
                    capture    = 1'b1;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                if (!psel || !penable) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end else if (cnt == WAIT_LAST) begin
                    next_state = RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RESP: begin
                next_state = HOLD;
            end
            HOLD: begin
                if (!psel || !penable) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cap_idx   <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
        end else if (capture) begin
            cap_idx   <= paddr[IDX_W-1:0];
            cap_write <= pwrite;
            cap_wdata <= pwdata;
        end
    end

    assign idx_ok     = ({1'b0, cap_idx} < DEPTH_LIM);
    assign enter_resp = (state == WAIT) && (next_state == RESP);
    assign mem_we     = enter_resp && cap_write && idx_ok;

    apb_tgt_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_regfile (
        .clk    (clk),
        .nrst   (nrst),
        .we     (mem_we),
        .waddr  (cap_idx[AW-1:0]),
        .wdata  (cap_wdata),
        .raddr  (cap_idx[AW-1:0]),
        .rdata  (mem_rdata)
    );

    // Response outputs are loaded on the edge into RESP and are zero in every other state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pready <= 1'b0;
            prdata <= '0;
            perr   <= 1'b0;
        end else begin
            pready <= enter_resp;
            prdata <= (enter_resp && !cap_write && idx_ok) ? mem_rdata : '0;
            perr   <= enter_resp && !idx_ok;
        end
    end

endmodule
